// File: rtl/bcd_serial_addsub_if.sv
// Handshake and operand/result bundle for the serial packed-BCD adder/subtractor.
//   master : controller side, drives start/sub/carry_in/a/b and watches the results
//   slave  : datapath side, consumes the request and returns busy/done/sum/carry_out/err
// DIGITS sets the operand width W = 4*DIGITS (digit 0 in bits [3:0]).
interface bcd_serial_addsub_if #(
  parameter int DIGITS = 4
);
  localparam int W = 4 * DIGITS;

  logic         start;
  logic         sub;
  logic         carry_in;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         err;

  modport master (
    output start, sub, carry_in, a, b,
    input  busy, done, sum, carry_out, err
  );

  modport slave (
    input  start, sub, carry_in, a, b,
    output busy, done, sum, carry_out, err
  );
endinterface

// File: rtl/bcd_serial_addsub.sv
// Multi-digit packed-BCD adder/subtractor, one decimal digit per clock, LSD first.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : bcd_serial_addsub_if.slave
//           start/sub/carry_in/a/b in; busy/done/sum/carry_out/err out
// A request is accepted in IDLE or DONE; the operation then takes DIGITS
// cycles and done pulses for one cycle with sum/carry_out/err updated.
// Subtraction adds the nine's complement of each b digit with an inverted
// borrow-in, giving the ten's complement result and carry_out = no-borrow.
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input logic              clk,
  input logic              rst_n,
  bcd_serial_addsub_if.slave bus
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One decimal digit step: returns {carry, digit}. For subtraction b is
  // replaced by its nine's complement (mod 16 so invalid digits stay defined).
  function automatic logic [4:0] digit_step(
    input logic [3:0] a_d,
    input logic [3:0] b_d,
    input logic       sub_op,
    input logic       c_in
  );
    logic [3:0] bd;
    logic [4:0] t;
    logic [4:0] t6;
    if (sub_op) begin
      bd = 4'd9 - b_d;
    end else begin
      bd = b_d;
    end
    t  = {1'b0, a_d} + {1'b0, bd} + {4'b0000, c_in};
    t6 = t + 5'd6;
    if (t > 5'd9) begin
      digit_step = {1'b1, t6[3:0]};
    end else begin
      digit_step = {1'b0, t[3:0]};
    end
  endfunction

  // A packed-BCD digit is invalid when it exceeds 9.
  function automatic logic digit_bad(input logic [3:0] d);
    digit_bad = (d > 4'd9);
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  logic             accept_s;
  logic             step_s;
  logic             last_s;

  // Operands are shifted right one digit per step so the current digit is
  // always at [3:0].
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic             sub_r;
  logic             c_r;
  logic [W-1:0]     work_r;
  logic             err_acc_r;
  logic [IDX_W-1:0] idx_r;

  logic [W-1:0]     sum_r;
  logic             carry_out_r;
  logic             err_r;
  logic             busy_r;
  logic             done_r;

  logic [4:0]       digit_res_s;
  logic             bad_s;
  logic [W+3:0]     work_ext_s;
  logic [W-1:0]     work_shift_s;

  // Current digit arithmetic and shift-in of the new result digit.
  always_comb begin
    digit_res_s  = digit_step(a_r[3:0], b_r[3:0], sub_r, c_r);
    bad_s        = digit_bad(a_r[3:0]) | digit_bad(b_r[3:0]);
    // New digit enters at the top; after DIGITS steps digit i sits at [4i+3:4i].
    work_ext_s   = {digit_res_s[3:0], work_r};
    work_shift_s = work_ext_s[W+3:4];
  end

  // Next-state and control strobes of the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    step_s       = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_next_s = ST_RUN;
          accept_s     = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        step_s = 1'b1;
        if (idx_r == LAST_IDX) begin
          last_s       = 1'b1;
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand latch, digit-serial datapath and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r         <= '0;
      b_r         <= '0;
      sub_r       <= 1'b0;
      c_r         <= 1'b0;
      work_r      <= '0;
      err_acc_r   <= 1'b0;
      idx_r       <= '0;
      sum_r       <= '0;
      carry_out_r <= 1'b0;
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else if (accept_s) begin
      a_r       <= bus.a;
      b_r       <= bus.b;
      sub_r     <= bus.sub;
      // Borrow-in becomes an inverted carry into the nine's-complement sum.
      c_r       <= bus.carry_in ^ bus.sub;
      work_r    <= '0;
      err_acc_r <= 1'b0;
      idx_r     <= '0;
      busy_r    <= 1'b1;
      done_r    <= 1'b0;
    end else if (step_s) begin
      a_r       <= a_r >> 3'd4;
      b_r       <= b_r >> 3'd4;
      c_r       <= digit_res_s[4];
      work_r    <= work_shift_s;
      err_acc_r <= err_acc_r | bad_s;
      idx_r     <= idx_r + 1'b1;
      if (last_s) begin
        sum_r       <= work_shift_s;
        carry_out_r <= digit_res_s[4];
        err_r       <= err_acc_r | bad_s;
        busy_r      <= 1'b0;
        done_r      <= 1'b1;
      end else begin
        done_r      <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.sum       = sum_r;
  assign bus.carry_out = carry_out_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench for bcd_serial_addsub (DIGITS=4 and DIGITS=1 instances).
module tb_bcd_serial_addsub;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  bcd_serial_addsub_if #(.DIGITS(4)) bus4 ();
  bcd_serial_addsub_if #(.DIGITS(1)) bus1 ();

  bcd_serial_addsub #(.DIGITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  bcd_serial_addsub #(.DIGITS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // ---------------- reference model: plain decimal arithmetic ----------------
  function automatic int bcd2int(input logic [15:0] v, input int nd);
    int r = 0;
    for (int i = nd - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v, input int nd);
    logic [15:0] r = '0;
    int x = v;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Returns {carry_out, sum}
  function automatic logic [16:0] ref_op(input logic s, input logic ci,
                                         input logic [15:0] av, input logic [15:0] bv, input int nd);
    int pw = 1;
    int aa, bb, r;
    logic co;
    for (int i = 0; i < nd; i++) pw = pw * 10;
    aa = bcd2int(av, nd);
    bb = bcd2int(bv, nd);
    if (!s) begin
      r  = aa + bb + int'(ci);
      co = (r >= pw);
      r  = r % pw;
    end else begin
      co = (aa >= bb + int'(ci));
      r  = (pw + aa - bb - int'(ci)) % pw;
    end
    return {co, int2bcd(r, nd)};
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'($urandom_range(9, 0));
    return r;
  endfunction

  // ---------------- stimulus helpers (no checking inside) ----------------
  // lat counts negedges after the accepting edge until done is seen.
  task automatic run4(input logic s, input logic ci, input logic [15:0] av, input logic [15:0] bv,
                      output int lat, output int busy_n, output logic [15:0] sm,
                      output logic co, output logic er);
    @(negedge clk);
    bus4.start = 1'b1; bus4.sub = s; bus4.carry_in = ci; bus4.a = av; bus4.b = bv;
    @(posedge clk);
    #1;
    bus4.start = 1'b0;
    // scramble inputs: the operation must use the latched values
    bus4.a = 16'($urandom); bus4.b = 16'($urandom); bus4.sub = ~s; bus4.carry_in = ~ci;
    lat = 0; busy_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (bus4.busy) busy_n++;
      if (bus4.done) break;
    end
    sm = bus4.sum; co = bus4.carry_out; er = bus4.err;
  endtask

  task automatic run1(input logic ci, input logic [3:0] av, input logic [3:0] bv,
                      output int lat, output logic [3:0] sm, output logic co);
    @(negedge clk);
    bus1.start = 1'b1; bus1.sub = 1'b0; bus1.carry_in = ci; bus1.a = av; bus1.b = bv;
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (bus1.done) break;
    end
    sm = bus1.sum; co = bus1.carry_out;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus4.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus4.busy); else passed++;
    checks++; if (bus4.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus4.done); else passed++;
    checks++; if (bus4.sum !== 16'h0000) $display("FAIL reset_sum: got %h expected 0000", bus4.sum); else passed++;
    checks++; if (bus4.carry_out !== 1'b0) $display("FAIL reset_cout: got %b expected 0", bus4.carry_out); else passed++;
    checks++; if (bus4.err !== 1'b0) $display("FAIL reset_err: got %b expected 0", bus4.err); else passed++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus4.done !== 1'b0 || bus4.busy !== 1'b0)
      $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", bus4.busy, bus4.done); else passed++;
  endtask

  task automatic test_add_zero();
    int lat, bn; logic [15:0] sm; logic co, er;
    run4(1'b0, 1'b0, 16'h0000, 16'h0000, lat, bn, sm, co, er);
    checks++; if (lat !== 5) $display("FAIL add0_latency: got %0d negedges expected 5", lat); else passed++;
    checks++; if (bn !== 4) $display("FAIL add0_busy_cycles: got %0d expected 4", bn); else passed++;
    checks++; if (sm !== 16'h0000) $display("FAIL add0_sum: got %h expected 0000", sm); else passed++;
    checks++; if (co !== 1'b0) $display("FAIL add0_cout: got %b expected 0", co); else passed++;
    checks++; if (er !== 1'b0) $display("FAIL add0_err: got %b expected 0", er); else passed++;
    @(negedge clk);
    checks++; if (bus4.done !== 1'b0) $display("FAIL add0_done_width: got %b expected 0", bus4.done); else passed++;
  endtask

  task automatic test_directed();
    logic [15:0] ta [5] = '{16'h1234, 16'h9999, 16'h5000, 16'h0000, 16'h0042};
    logic [15:0] tb_ [5] = '{16'h5678, 16'h0001, 16'h1234, 16'h0001, 16'h0042};
    logic        ts [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        tc [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] es [5] = '{16'h6913, 16'h0000, 16'h3766, 16'h9999, 16'h9999};
    logic        ec [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int lat, bn; logic [15:0] sm; logic co, er;
    for (int i = 0; i < 5; i++) begin
      run4(ts[i], tc[i], ta[i], tb_[i], lat, bn, sm, co, er);
      checks++; if (sm !== es[i]) $display("FAIL directed%0d_sum: got %h expected %h", i, sm, es[i]); else passed++;
      checks++; if (co !== ec[i]) $display("FAIL directed%0d_cout: got %b expected %b", i, co, ec[i]); else passed++;
    end
  endtask

  task automatic test_invalid();
    int lat, bn; logic [15:0] sm; logic co, er;
    run4(1'b0, 1'b0, 16'h00A0, 16'h0001, lat, bn, sm, co, er);
    checks++; if (er !== 1'b1) $display("FAIL invalid_err: got %b expected 1", er); else passed++;
    run4(1'b0, 1'b0, 16'h0001, 16'h0001, lat, bn, sm, co, er);
    checks++; if (er !== 1'b0) $display("FAIL invalid_clear_err: got %b expected 0", er); else passed++;
    checks++; if (sm !== 16'h0002) $display("FAIL invalid_next_sum: got %h expected 0002", sm); else passed++;
  endtask

  task automatic test_random();
    int lat, bn; logic [15:0] sm; logic co, er;
    logic [15:0] av, bv; logic s, ci; logic [16:0] exp_r; bit bad;
    for (int n = 0; n < 40; n++) begin
      av = rand_bcd(); bv = rand_bcd();
      s = 1'($urandom_range(1, 0)); ci = 1'($urandom_range(1, 0));
      bad = ($urandom_range(4, 0) == 0);
      if (bad) begin
        if ($urandom_range(1, 0) == 1) av[4*$urandom_range(3, 0) +: 4] = 4'($urandom_range(15, 10));
        else bv[4*$urandom_range(3, 0) +: 4] = 4'($urandom_range(15, 10));
      end
      run4(s, ci, av, bv, lat, bn, sm, co, er);
      if (bad) begin
        checks++; if (er !== 1'b1) $display("FAIL rand%0d_err: got %b expected 1", n, er); else passed++;
      end else begin
        exp_r = ref_op(s, ci, av, bv, 4);
        checks++; if (sm !== exp_r[15:0] || co !== exp_r[16] || er !== 1'b0)
          $display("FAIL rand%0d: %h %s %h c%b got sum=%h cout=%b err=%b expected sum=%h cout=%b err=0",
                   n, av, s ? "-" : "+", bv, ci, sm, co, er, exp_r[15:0], exp_r[16]);
        else passed++;
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [15:0] prev; int dones = 0;
    logic [16:0] exp_r;
    prev = bus4.sum;
    exp_r = ref_op(1'b0, 1'b0, 16'h2468, 16'h1357, 4);
    @(negedge clk);
    bus4.start = 1'b1; bus4.sub = 1'b0; bus4.carry_in = 1'b0; bus4.a = 16'h2468; bus4.b = 16'h1357;
    @(posedge clk);
    #1;
    bus4.start = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      bus4.start = (i >= 1 && i <= 3);
      bus4.a = 16'h9999;
      if (i == 3) begin
        checks++; if (bus4.sum !== prev) $display("FAIL hold_sum_in_run: got %h expected %h", bus4.sum, prev); else passed++;
      end
      if (bus4.done) dones++;
    end
    bus4.start = 1'b0;
    checks++; if (dones !== 1) $display("FAIL ignored_start_dones: got %0d expected 1", dones); else passed++;
    checks++; if (bus4.sum !== exp_r[15:0]) $display("FAIL ignored_start_sum: got %h expected %h", bus4.sum, exp_r[15:0]); else passed++;
    checks++; if (bus4.busy !== 1'b0) $display("FAIL ignored_start_idle: got busy=%b expected 0", bus4.busy); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] oa [4] = '{16'h1111, 16'h0999, 16'h8000, 16'h4321};
    logic [15:0] ob [4] = '{16'h2222, 16'h0001, 16'h0123, 16'h1111};
    logic        os [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [16:0] exp_r;
    int j = 0; int last = 0;
    @(negedge clk);
    bus4.start = 1'b1; bus4.sub = os[0]; bus4.carry_in = 1'b0; bus4.a = oa[0]; bus4.b = ob[0];
    for (int cyc = 1; cyc <= 60 && j < 4; cyc++) begin
      @(negedge clk);
      if (bus4.done) begin
        exp_r = ref_op(os[j], 1'b0, oa[j], ob[j], 4);
        checks++; if (bus4.sum !== exp_r[15:0] || bus4.carry_out !== exp_r[16])
          $display("FAIL b2b%0d: got sum=%h cout=%b expected sum=%h cout=%b", j, bus4.sum, bus4.carry_out, exp_r[15:0], exp_r[16]);
        else passed++;
        if (j > 0) begin
          checks++; if (cyc - last !== 5) $display("FAIL b2b%0d_period: got %0d expected 5", j, cyc - last); else passed++;
        end
        last = cyc;
        j++;
        if (j < 4) begin
          bus4.sub = os[j]; bus4.a = oa[j]; bus4.b = ob[j];
        end else begin
          bus4.start = 1'b0;
        end
      end
    end
    bus4.start = 1'b0;
    checks++; if (j !== 4) $display("FAIL b2b_count: got %0d results expected 4", j); else passed++;
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    @(negedge clk);
    bus4.start = 1'b1; bus4.sub = 1'b0; bus4.carry_in = 1'b0; bus4.a = 16'h1234; bus4.b = 16'h1111;
    @(posedge clk);
    #1;
    bus4.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus4.busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", bus4.busy); else passed++;
    checks++; if (bus4.done !== 1'b0) $display("FAIL rstmid_done: got %b expected 0", bus4.done); else passed++;
    checks++; if (bus4.sum !== 16'h0000) $display("FAIL rstmid_sum: got %h expected 0000", bus4.sum); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus4.done) dones++;
    end
    checks++; if (dones !== 0) $display("FAIL rstmid_no_done: got %0d pulses expected 0", dones); else passed++;
  endtask

  task automatic test_digits1();
    logic [3:0] ta [4] = '{4'd5, 4'd9, 4'd8, 4'd4};
    logic [3:0] tb_ [4] = '{4'd9, 4'd9, 4'd2, 4'd5};
    logic       tc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] es [4] = '{4'd4, 4'd9, 4'd0, 4'd9};
    logic       ec [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int lat; logic [3:0] sm; logic co; logic [16:0] exp_r;
    for (int i = 0; i < 4; i++) begin
      run1(tc[i], ta[i], tb_[i], lat, sm, co);
      checks++; if (sm !== es[i] || co !== ec[i])
        $display("FAIL d1_case%0d: got sum=%h cout=%b expected sum=%h cout=%b", i, sm, co, es[i], ec[i]);
      else passed++;
      checks++; if (lat !== 2) $display("FAIL d1_latency%0d: got %0d negedges expected 2", i, lat); else passed++;
    end
    for (int n = 0; n < 10; n++) begin
      ta[0] = 4'($urandom_range(9, 0)); tb_[0] = 4'($urandom_range(9, 0)); tc[0] = 1'($urandom_range(1, 0));
      exp_r = ref_op(1'b0, tc[0], {12'h000, ta[0]}, {12'h000, tb_[0]}, 1);
      run1(tc[0], ta[0], tb_[0], lat, sm, co);
      checks++; if (sm !== exp_r[3:0] || co !== exp_r[16])
        $display("FAIL d1_rand%0d: %0d+%0d+%b got sum=%h cout=%b expected sum=%h cout=%b",
                 n, ta[0], tb_[0], tc[0], sm, co, exp_r[3:0], exp_r[16]);
      else passed++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus4.start = 1'b0; bus4.sub = 1'b0; bus4.carry_in = 1'b0; bus4.a = '0; bus4.b = '0;
    bus1.start = 1'b0; bus1.sub = 1'b0; bus1.carry_in = 1'b0; bus1.a = '0; bus1.b = '0;
    test_reset();
    test_add_zero();
    test_directed();
    test_invalid();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_digits1();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
